// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// datapath mux selects and the immediate-format decode helper.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC,
    S_LUI, S_AUIPC, S_ERR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch-taken decision from funct3 and the ALU compare flags.
module branch_cond
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = zero;
      F3_BNE:           taken = !zero;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = !lt;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore multicycle control FSM with memory ready/timeout handling and an
// instret counter. Define MC_ILLEGAL_TRAP_EN to trap unlisted opcodes into ERR.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic                 bus_err,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   bus_err_q, bus_err_d;
  logic                   br_taken;
  logic                   timeout_hit;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .taken  (br_taken)
  );

  assign imm_src = imm_src_of(op);
  assign bus_err = bus_err_q;
  assign instret = instret_q;

  // Moore strobes; only the fetch enables and branch pc_write look at inputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_SUB;
        pc_write  = br_taken;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_JALR_PC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      default: ;
    endcase
  end

  // Completion is checked before the timeout so a late ready still wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_q == WAIT_LAST);

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d   = S_ERR;
            illegal_d = 1'b1;
`else
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_JALR_PC, S_AUIPC: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      S_JALR:     state_d = S_JALR_PC;
      default:    state_d = state_q;
    endcase
    if (timeout_hit) begin
      state_d   = S_ERR;
      bus_err_d = 1'b1;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (mem_req && !mem_ready)
      wait_d = wait_q + WAIT_W'(1);
  end

  always_comb begin
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
      instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model
// predicts every cycle's strobes, flags and instret for the DUT to match.
module tb_multicycle_controller;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       bus_err, illegal_op;
  logic [3:0] instret;

  multicycle_controller #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .bus_err(bus_err), .illegal_op(illegal_op), .instret(instret)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [3:0] m_instret = '0;
  logic       m_bus_err = 1'b0;
  logic       m_ill = 1'b0;

  function automatic logic [13:0] ctl(input logic mr, mw, as, irw, pcw, rw,
                                      input logic [1:0] a, b, aop, rs);
    return {mr, mw, as, irw, pcw, rw, a, b, aop, rs};
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] o);
    if (o == ST) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JL) return 3'b011;
    if (o == LU || o == AU) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic m_taken(input logic [2:0] f3, input logic z, input logic l);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4 || f3 == 3'd6) return l;
    if (f3 == 3'd5 || f3 == 3'd7) return !l;
    return 1'b0;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive ready, compare every output at the falling edge.
  task automatic step(input logic [13:0] exp_ctl, input logic rdy, input string tag);
    logic [22:0] act, exp;
    mem_ready = rdy;
    @(negedge clk);
    act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, bus_err, illegal_op, instret};
    exp = {exp_ctl, m_imm(op), m_bus_err, m_ill, m_instret};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d op=%b: got ctl=%b imm=%b berr=%b ill=%b instret=%0d, expected ctl=%b imm=%b berr=%b ill=%b instret=%0d",
               tag, cyc, op, act[22:9], act[8:6], act[5], act[4], act[3:0],
               exp[22:9], exp[8:6], exp[5], exp[4], exp[3:0]);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mem_access(input int waits, input logic wr, input string tag);
    for (int i = 0; i < waits; i++) step(ctl(1, wr, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, tag);
    step(ctl(1, wr, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, tag);
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) step(ctl(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b0, "fetch_wait");
    step(ctl(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b1, "fetch");
  endtask

  task automatic err_cycles(input int n);
    for (int i = 0; i < n; i++) step('0, rnd(), "err");
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    m_instret = '0; m_bus_err = 1'b0; m_ill = 1'b0;
    step('0, rnd(), "in_reset");
    rst_n = 1'b1;
    step('0, rnd(), "idle");
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic z, input logic l,
                     input int fw, input int mw, output int cycles);
    int   c0;
    logic retired;
    c0 = cyc; retired = 1'b1;
    op = o; funct3 = f3; zero = z; lt = l;
    fetch(fw);
    step(ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), rnd(), "decode");
    case (o)
      LD: begin
        step(ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rnd(), "memadr");
        mem_access(mw, 1'b0, "memread");
        step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01), rnd(), "memwb");
      end
      ST: begin
        step(ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rnd(), "memadr");
        mem_access(mw, 1'b1, "memwrite");
      end
      RT, IT: begin
        step(ctl(0, 0, 0, 0, 0, 0, 2'b10, (o == IT) ? 2'b01 : 2'b00, 2'b10, 2'b00), rnd(), "exec");
        step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rnd(), "aluwb");
      end
      BR: step(ctl(0, 0, 0, 0, m_taken(f3, z, l), 0, 2'b10, 2'b00, 2'b01, 2'b00), rnd(), "branch");
      JL: begin
        step(ctl(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00), rnd(), "jal");
        step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rnd(), "aluwb");
      end
      JR: begin
        step(ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), rnd(), "jalr");
        step(ctl(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00), rnd(), "jalr_pc");
        step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rnd(), "aluwb");
      end
      LU: step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11), rnd(), "lui");
      AU: begin
        step(ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), rnd(), "auipc");
        step(ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), rnd(), "aluwb");
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        m_ill = 1'b1;
        retired = 1'b0;
        err_cycles(3);
`endif
      end
    endcase
    if (retired) m_instret = m_instret + 4'd1;
    cycles = cyc - c0;
  endtask

  function automatic logic [6:0] pick_op(input int idx);
    case (idx)
      0: return LD; 1: return ST; 2: return RT; 3: return IT; 4: return BR;
      5: return JL; 6: return JR; 7: return LU; 8: return AU;
      default: return BAD;
    endcase
  endfunction

  initial begin
    int n;
    @(posedge clk);
    #1;
    reset_pulse();

    // Load with one wait in fetch and one in memread.
    run(LD, 3'd2, 1'b0, 1'b0, 1, 1, n);
    chk("lw_cycles", n, 7);
    chk("instret_after_lw", int'(instret), 1);

    run(BR, 3'd0, 1'b1, 1'b0, 0, 0, n);
    chk("beq_taken_cycles", n, 3);
    run(BR, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk("beq_not_taken_cycles", n, 3);

    // Ready arriving on the cycle the wait counter reaches the limit completes.
    run(ST, 3'd2, 1'b0, 1'b0, 3, 3, n);
    chk("sw_max_wait_cycles", n, 10);
    run(JR, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk("jalr_cycles", n, 5);

    for (int i = 0; i < 80; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      n = int'($urandom_range(0, 8));
`else
      n = int'($urandom_range(0, 9));
`endif
      run(pick_op(n), 3'($urandom_range(0, 7)), rnd(), rnd(),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), n);
    end

    // Illegal opcode.
    run(BAD, 3'd0, 1'b0, 1'b0, 0, 0, n);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_op_set", int'(illegal_op), 1);
    reset_pulse();
`else
    chk("illegal_nop_cycles", n, 2);
    chk("illegal_op_low", int'(illegal_op), 0);
`endif

    // Async reset in the middle of a store.
    op = ST; funct3 = 3'd2;
    fetch(0);
    step(ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), 1'b0, "decode");
    step(ctl(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00), 1'b0, "memadr");
    mem_ready = 1'b0;
    #1;
    chk("memwrite_req_before_reset", int'({mem_req, mem_write}), 3);
    rst_n = 1'b0;
    #1;
    chk("mem_req_async_drop", int'(mem_req), 0);
    chk("mem_write_async_drop", int'(mem_write), 0);
    @(posedge clk);
    #1;
    reset_pulse();

    // instret wrap with a 4-bit counter.
    for (int i = 0; i < 15; i++) run(LU, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk("instret_15", int'(instret), 15);
    run(LU, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk("instret_wrap", int'(instret), 0);
    chk("lui_cycles", n, 3);

    // Timeout in fetch: four stalled cycles then ERR until reset.
    op = LU;
    for (int i = 0; i < 4; i++) step(ctl(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b0, "fetch_stall");
    m_bus_err = 1'b1;
    err_cycles(4);
    chk("bus_err_sticky", int'(bus_err), 1);
    reset_pulse();
    chk("bus_err_cleared", int'(bus_err), 0);
    run(LU, 3'd0, 1'b0, 1'b0, 2, 0, n);
    chk("lui_after_recovery", int'(instret), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
